// File: rtl/scan_chain_pkg.sv
// scan_chain_pkg: shared FSM state encoding and sizing helpers for the
// scan chain controller.
package scan_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        FIN
    } state_e;

    // Number of host words needed to fill the whole chain.
    function automatic int words_per_chain(input int chain_len, input int word_w);
        return chain_len / word_w;
    endfunction

    // Width of the bit-within-word counter.
    function automatic int bit_cnt_w(input int word_w);
        return $clog2(word_w);
    endfunction

    // Width of the word counter; it must be able to hold the full word count.
    function automatic int word_cnt_w(input int chain_len, input int word_w);
        return $clog2(words_per_chain(chain_len, word_w) + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_ser.sv
// scan_chain_ctrl_ser: one-word parallel-to-serial buffer feeding the chain
// head, plus the serial-to-parallel readback register fed from the chain tail.
// The readback register exists only when SCAN_CHAIN_READBACK_EN is defined.
module scan_chain_ctrl_ser
    import scan_chain_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BC_W   = bit_cnt_w(WORD_W)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              load_en_i,
    input  logic              shift_en_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [BC_W-1:0]   bit_idx_i,
`ifdef SCAN_CHAIN_READBACK_EN
    input  logic              so_i,
    output logic [WORD_W-1:0] rb_o,
`endif
    output logic              si_o
);

    logic [WORD_W-1:0] buf_q;

    // Hold the host word; the bit index selects which bit drives the head.
    // NOTE: these word-sized registers are reset so SI and out_data start at 0.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            // NOTE: state updates use non-blocking assignments so all flops
            // sample pre-edge values.
            buf_q <= '0;
        end else if (load_en_i) begin
            buf_q <= data_i;
        end
    end

    assign si_o = buf_q[bit_idx_i];

`ifdef SCAN_CHAIN_READBACK_EN
    logic [WORD_W-1:0] rb_q;

    // Tail bit sampled on shift cycle i lands in readback bit i.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            rb_q <= '0;
        end else if (shift_en_i) begin
            rb_q[bit_idx_i] <= so_i;
        end
    end

    assign rb_o = rb_q;
`endif

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: accepts host words over valid/ready, shifts them LSB-first
// into a scan chain and returns the bits leaving the chain tail as words.
// Readback (SO capture, DRAIN state, out_valid/out_data) is built only when
// SCAN_CHAIN_READBACK_EN is defined; otherwise out_valid/out_data are 0.
module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              SE,
    output logic              SI,
    input  logic              SO,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data
);

    localparam int WORDS = words_per_chain(CHAIN_LEN, WORD_W);
    localparam int BC_W  = bit_cnt_w(WORD_W);
    localparam int WC_W  = word_cnt_w(CHAIN_LEN, WORD_W);

    state_e          state_q;
    logic [BC_W-1:0] bit_cnt_q;
    logic [WC_W-1:0] word_cnt_q;
    logic            busy_q;
    logic            in_ready_q;
    logic            se_q;
    logic            done_q;
    logic            load_en;
    logic            shift_en;
    logic            si_bit;

    // A word is taken only in LOAD, where in_ready is known to be high.
    assign load_en  = (state_q == LOAD) && in_valid;
    assign shift_en = (state_q == SHIFT);

    scan_chain_ctrl_ser #(
        .WORD_W (WORD_W),
        .BC_W   (BC_W)
    ) u_ser (
        .CK         (CK),
        .RST        (RST),
        .load_en_i  (load_en),
        .shift_en_i (shift_en),
        .data_i     (in_data),
        .bit_idx_i  (bit_cnt_q),
`ifdef SCAN_CHAIN_READBACK_EN
        .so_i       (SO),
        .rb_o       (out_data),
`endif
        .si_o       (si_bit)
    );

`ifdef SCAN_CHAIN_READBACK_EN
    logic out_valid_q;
    assign out_valid = out_valid_q;
`else
    logic unused_inputs;
    assign unused_inputs = SO ^ out_ready;
    assign out_valid     = 1'b0;
    assign out_data      = '0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;
    assign SE       = se_q;
    // SI is gated so the head sees 0 whenever the chain is not shifting.
    assign SI       = se_q & si_bit;

    // Session FSM with counters and registered handshake/scan outputs; the
    // async reset drops SE immediately so the chain freezes mid-session.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            se_q        <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCAN_CHAIN_READBACK_EN
            out_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        se_q       <= 1'b1;
                        bit_cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                        se_q       <= 1'b0;
                        word_cnt_q <= word_cnt_q + WC_W'(1);
`ifdef SCAN_CHAIN_READBACK_EN
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
`else
                        if (word_cnt_q == WC_W'(WORDS - 1)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    end
                end
`ifdef SCAN_CHAIN_READBACK_EN
                DRAIN: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (word_cnt_q == WC_W'(WORDS)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
`endif
                FIN: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    word_cnt_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl with a 16-cell scan
// chain model (chain[0] is the tail driving SO, chain[15] the head).
// Expectations follow SCAN_CHAIN_READBACK_EN the same way the RTL does.
module tb_scan_chain_ctrl;

    localparam int CHAIN_LEN = 16;
    localparam int WORD_W    = 8;
`ifdef SCAN_CHAIN_READBACK_EN
    localparam int EXP_LEN = 20;
`else
    localparam int EXP_LEN = 18;
`endif

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;
    logic        SO;
    logic        busy, done, in_ready, SE, SI, out_valid;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_cnt = 0;
    int ov_cnt = 0;

    logic [15:0] chain;
    logic        preload_req = 1'b0;
    logic [15:0] preload_val = '0;

    scan_chain_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .SE        (SE),
        .SI        (SI),
        .SO        (SO),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 CK = ~CK;

    // Scan chain: shifts toward the tail while SE is high.
    assign SO = chain[0];
    always @(posedge CK) begin
        if (preload_req) chain <= preload_val;
        else if (SE)     chain <= {SI, chain[15:1]};
    end

    // Event counters sampled on the active edge.
    always @(posedge CK) begin
        cycle <= cycle + 1;
        if (done)      done_cnt <= done_cnt + 1;
        if (out_valid) ov_cnt   <= ov_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic preload(input logic [15:0] v);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge CK);
        preload_req = 1'b0;
    endtask

    // Drives one two-word session and records what it observed.
    task automatic run_session(input logic [15:0] words, input int in_stall,
                               input int out_stall, output logic [15:0] rb,
                               output int se0, output int se1, output int len,
                               output int bad, output bit rdy0, output bit timeout);
        int wait_cnt;
        int t0;
        logic [7:0]  hold;
        logic [15:0] snap;
        rb = '0; se0 = 0; se1 = 0; bad = 0; timeout = 1'b0;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        t0   = cycle;
        rdy0 = in_ready;
        for (int k = 0; k < 2; k++) begin
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 40) begin
                @(negedge CK);
                wait_cnt++;
            end
            if (!in_ready) timeout = 1'b1;
            if (k == 0) begin
                for (int s = 0; s < in_stall; s++) begin
                    if (SE || !busy || !in_ready) bad++;
                    @(negedge CK);
                end
            end
            in_valid = 1'b1;
            in_data  = words[8*k +: 8];
            @(negedge CK);
            in_valid = 1'b0;
            wait_cnt = 0;
            while (SE && wait_cnt < 40) begin
                if (k == 0) se0++;
                else        se1++;
                @(negedge CK);
                wait_cnt++;
            end
            if (SE) timeout = 1'b1;
`ifdef SCAN_CHAIN_READBACK_EN
            if (!out_valid) timeout = 1'b1;
            if (k == 0) begin
                hold = out_data;
                snap = chain;
                for (int s = 0; s < out_stall; s++) begin
                    @(negedge CK);
                    if (SE || !out_valid || out_data !== hold || chain !== snap) bad++;
                end
            end
            rb[8*k +: 8] = out_data;
            out_ready = 1'b1;
            @(negedge CK);
            out_ready = 1'b0;
`endif
        end
        wait_cnt = 0;
        while (!done && wait_cnt < 40) begin
            @(negedge CK);
            wait_cnt++;
        end
        if (!done) timeout = 1'b1;
        len = cycle - t0;
        @(negedge CK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CK);
        checks++;
        if ({busy, done, in_ready, SE, SI, out_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {busy, done, in_ready, SE, SI, out_valid});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 00", out_data);
        end
        RST = 1'b0;
        in_valid = 1'b1;   // must be ignored outside LOAD
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            checks++;
            if ({busy, done, in_ready, SE, out_valid} !== 5'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %b expected 00000", i, {busy, done, in_ready, SE, out_valid});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_session();
        logic [15:0] rb;
        int se0, se1, len, bad, d0, ov0;
        bit rdy0, to;
        preload(16'hBEEF);
        d0  = done_cnt;
        ov0 = ov_cnt;
        run_session(16'h3CA5, 0, 0, rb, se0, se1, len, bad, rdy0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL full_timeout: got %b expected 0", to); end
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL full_ready_after_start: got %b expected 1", rdy0); end
        checks++;
        if (se0 !== 8 || se1 !== 8) begin errors++; $display("FAIL full_se_cycles: got %0d/%0d expected 8/8", se0, se1); end
        checks++;
        if (len !== EXP_LEN) begin errors++; $display("FAIL full_len: got %0d expected %0d", len, EXP_LEN); end
`ifdef SCAN_CHAIN_READBACK_EN
        checks++;
        if (rb !== 16'hBEEF) begin errors++; $display("FAIL full_readback: got %h expected beef", rb); end
`else
        checks++;
        if (ov_cnt - ov0 !== 0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL full_no_readback: got %0d valids data %h expected 0 valids data 00", ov_cnt - ov0, out_data);
        end
`endif
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (chain !== 16'h3CA5) begin errors++; $display("FAIL full_chain: got %h expected 3ca5", chain); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [15:0] rb;
        int se0, se1, len, bad, exp_len;
        bit rdy0, to;
        preload(16'h1234);
        run_session(16'hC35A, 0, 5, rb, se0, se1, len, bad, rdy0, to);
`ifdef SCAN_CHAIN_READBACK_EN
        exp_len = EXP_LEN + 5;
        checks++;
        if (rb !== 16'h1234) begin errors++; $display("FAIL bp_readback: got %h expected 1234", rb); end
`else
        exp_len = EXP_LEN;
`endif
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", to); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad); end
        checks++;
        if (len !== exp_len) begin errors++; $display("FAIL bp_len: got %0d expected %0d", len, exp_len); end
        checks++;
        if (chain !== 16'hC35A) begin errors++; $display("FAIL bp_chain: got %h expected c35a", chain); end
    endtask

    task automatic test_host_stall();
        logic [15:0] rb;
        int se0, se1, len, bad, d0;
        bit rdy0, to;
        preload(16'h0F0F);
        d0 = done_cnt;
        run_session(16'h00FF, 7, 0, rb, se0, se1, len, bad, rdy0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %b expected 0", to); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_no_se_busy: got %0d bad cycles expected 0", bad); end
        checks++;
        if (se0 !== 8) begin errors++; $display("FAIL stall_se_cycles: got %0d expected 8", se0); end
        checks++;
        if (len !== EXP_LEN + 7) begin errors++; $display("FAIL stall_len: got %0d expected %0d", len, EXP_LEN + 7); end
`ifdef SCAN_CHAIN_READBACK_EN
        checks++;
        if (rb !== 16'h0F0F) begin errors++; $display("FAIL stall_readback: got %h expected 0f0f", rb); end
`endif
        checks++;
        if (chain !== 16'h00FF) begin errors++; $display("FAIL stall_chain: got %h expected 00ff", chain); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] rb;
        int se0, se1, len, bad, d0;
        bit rdy0, to;
        preload(16'hBEEF);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge CK);
        in_valid = 1'b0;
        repeat (3) @(negedge CK);   // now inside the 4th shift cycle
        checks++;
        if (SE !== 1'b1) begin errors++; $display("FAIL rst_pre_se: got %b expected 1", SE); end
        RST = 1'b1;
        #1;
        checks++;
        if ({busy, done, in_ready, SE, SI, out_valid} !== 6'b0) begin
            errors++;
            $display("FAIL rst_async_flags: got %b expected 000000", {busy, done, in_ready, SE, SI, out_valid});
        end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        @(negedge CK);
        RST = 1'b0;
        @(negedge CK);
        // Three bits of 0xA5 (1,0,1) entered the head of 0xBEEF.
        checks++;
        if (chain !== 16'hB7DD) begin errors++; $display("FAIL rst_chain_kept: got %h expected b7dd", chain); end
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL rst_no_done: got %0d expected %0d", done_cnt, d0); end
        run_session(16'h2211, 0, 0, rb, se0, se1, len, bad, rdy0, to);
        checks++;
        if (to !== 1'b0 || len !== EXP_LEN) begin
            errors++;
            $display("FAIL rst_resume_len: got timeout %b len %0d expected timeout 0 len %0d", to, len, EXP_LEN);
        end
`ifdef SCAN_CHAIN_READBACK_EN
        checks++;
        if (rb !== 16'hB7DD) begin errors++; $display("FAIL rst_resume_readback: got %h expected b7dd", rb); end
`endif
        checks++;
        if (chain !== 16'h2211) begin errors++; $display("FAIL rst_resume_chain: got %h expected 2211", chain); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rst_resume_done: got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_full_session();
        test_backpressure();
        test_host_stall();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Serializing controller that drives the scan input side of a configuration chain built from scan flip-flops (SE/SI/Q). It accepts parallel words from a host over a valid/ready handshake, shifts them bit-serially into the chain head, and reassembles the bits returning from the chain tail into readback words. It sits between the configuration host interface and the fabric's scan chain.

## Interface
- CHAIN_LEN, 64, number of flip-flops in the chain; must be a nonzero multiple of WORD_W
- WORD_W, 8, width of host and readback words; at least 2
- CK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request to begin a chain session; honoured only in IDLE
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses
- done  output  1  one-cycle pulse after the last word has been shifted and its readback accepted
- in_valid  input  1  host word valid
- in_ready  output  1  controller can accept a word
- in_data  input  WORD_W  host word; bit 0 is shifted first
- SE  output  1  scan enable to every chain cell
- SI  output  1  serial data to the chain head
- SO  input  1  Q of the chain tail cell
- out_valid  output  1  readback word valid
- out_ready  input  1  consumer accepts readback word
- out_data  output  WORD_W  readback word; bit i is the tail bit sampled on shift cycle i

## Operation
- States: IDLE, LOAD, SHIFT, DRAIN, FIN.
- IDLE: busy=0, in_ready=0, SE=0. start=1 -> LOAD.
- LOAD: in_ready=1. On in_valid&&in_ready, latch in_data into shift buffer, clear bit counter -> SHIFT.
- SHIFT: SE=1, SI=buffer[bit_cnt]. On each edge, capture SO into rb[bit_cnt], increment bit_cnt. After WORD_W shift cycles, increment word_cnt and go to DRAIN.
- DRAIN: SE=0, out_valid=1, out_data=rb. On out_valid&&out_ready: if word_cnt==CHAIN_LEN/WORD_W -> FIN, else -> LOAD.
- FIN: done=1 for one cycle, word_cnt cleared -> IDLE.
- SE never high outside SHIFT; the chain holds its contents while the host or readback consumer stalls.
- start while busy is ignored; in_valid outside LOAD is ignored and not acknowledged.
- Counters: bit_cnt is $clog2(WORD_W) bits wide; word_cnt is $clog2(CHAIN_LEN/WORD_W+1) bits wide. No wrap within a session.
- A full session shifts exactly CHAIN_LEN bits. After the session, the chain holds the host words, and the readback stream equals the chain's prior contents, tail-first.

## Timing
- Reset values: in_ready=0, busy=0, done=0, SE=0, SI=0, out_valid=0, out_data=0. FSM=IDLE. Counters and buffers are 0.
- RST mid-session asserts SE=0 asynchronously. The chain keeps whatever bits were already shifted. No done pulse is produced.
- start accepted at edge t -> in_ready=1 in cycle t+1.
- Word accepted at edge t -> SE=1 for cycles t+1 to t+WORD_W. out_valid=1 from cycle t+WORD_W+1.
- Minimum per-word cost is WORD_W+2 cycles (LOAD, WORD_W×SHIFT, DRAIN) with in_valid and out_ready held high.
- All outputs are registered or decoded from the state register. in_ready does not depend combinationally on in_valid.

## Configuration
- SCAN_CHAIN_READBACK_EN defined: behaviour as above.
- SCAN_CHAIN_READBACK_EN undefined:
  - SO is ignored; rb registers are not built.
  - out_valid and out_data are tied to 0.
  - DRAIN is skipped: after the last shift, go to LOAD, or to FIN after the final word.
  - Per-word cost becomes WORD_W+1 cycles.

## Structure
- Package scan_chain_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DRAIN, FIN)
  - the localparam function computing words per chain
  - counter width helpers
- One sub-module, scan_chain_ctrl_ser: WORD_W parallel-to-serial buffer plus serial-to-parallel readback register, with shift and load enables. The FSM and counters live in the top module.

## Test plan
Bench setup: CHAIN_LEN=16, WORD_W=8, chain modelled as 16 scan flip-flops preloaded with 0xBEEF, tail first.
- Reset then idle: no start for 10 cycles -> SE=0, in_ready=0, out_valid=0, done=0 throughout.
- Full session: start, words 0xA5 then 0x3C, out_ready=1 -> readback 0xEF then 0xBE; done pulses once; chain holds 0x3CA5 with 0xA5 at the tail.
- Backpressure: out_ready=0 for 5 cycles in DRAIN -> SE stays 0 and out_data holds stable; chain is unchanged until release.
- Host stall: in_valid delayed 7 cycles in LOAD -> no SE pulses and busy stays 1.
- RST asserted on the 4th shift cycle -> SE falls before the next edge; all outputs return to reset values; a new session then completes normally.
- Build with SCAN_CHAIN_READBACK_EN undefined: same stimulus as the full session -> out_valid never asserts; done occurs 2 cycles earlier; chain holds 0x3CA5.
